// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pwm_capture_pkg                                            |
// | Brief   : Shared state encoding and saturation helper for pwm_capture|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_t;

  // Saturation value of a counter of the given width (widths up to 32).
  function automatic logic [31:0] all_ones(input int unsigned width);
    if (width >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_capture_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sync_edge                                                  |
// | Brief   : Optional 2-flop synchronizer plus edge flop (level/rise/fall)|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sync_edge #(
  parameter bit SYNC = 1'b1
) (
  input  logic sysclk,
  input  logic sysreset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic w_level;
  logic r_last;

  generate
    if (SYNC) begin : g_sync
      logic r_meta;
      logic r_sync;
      always_ff @(posedge sysclk) begin
        if (!sysreset_n) begin
          r_meta <= 1'b0;
          r_sync <= 1'b0;
        end else begin
          r_meta <= din;
          r_sync <= r_meta;
        end
      end
      assign w_level = r_sync;
    end else begin : g_bypass
      // Input is already in the sysclk domain; only the edge flop is needed.
      assign w_level = din;
    end
  endgenerate

  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      r_last <= 1'b0;
    end else begin
      r_last <= w_level;
    end
  end

  assign level = w_level;
  assign rise  = w_level & ~r_last;
  assign fall  = ~w_level & r_last;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pwm_capture                                                |
// | Brief   : Measures period and high time of a PWM input in timebase ticks|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pwm_capture #(
  parameter int WIDTH = 16
) (
  input  logic             sysclk,
  input  logic             sysreset_n,
  input  logic             counter_event,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             capture_valid,
  output logic             overrun,
  output logic             stuck_high,
  output logic             stuck_low,
  input  logic             ack
);

  import pwm_capture_pkg::*;

  localparam logic [31:0]      c_ones = all_ones(WIDTH);
  localparam logic [WIDTH-1:0] c_sat  = c_ones[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic w_pwm_s, w_rise, w_fall;
  logic w_tick, w_evt_level, w_evt_fall;
  logic w_unused_evt;

  sync_edge #(.SYNC(1'b1)) u_pwm_edge (
    .sysclk     (sysclk),
    .sysreset_n (sysreset_n),
    .din        (pwm_in),
    .level      (w_pwm_s),
    .rise       (w_rise),
    .fall       (w_fall)
  );

  sync_edge #(.SYNC(1'b0)) u_evt_edge (
    .sysclk     (sysclk),
    .sysreset_n (sysreset_n),
    .din        (counter_event),
    .level      (w_evt_level),
    .rise       (w_tick),
    .fall       (w_evt_fall)
  );

  assign w_unused_evt = w_evt_level ^ w_evt_fall;

  cap_state_t       r_state, w_state_next;
  logic [WIDTH-1:0] r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_hi_cap, w_hi_cap_next;
  logic [WIDTH-1:0] r_period, w_period_next;
  logic [WIDTH-1:0] r_high, w_high_next;
  logic             r_valid, w_valid_next;
  logic             r_overrun, w_overrun_next;
  logic             r_stuck_high, w_stuck_high_next;
  logic             r_stuck_low, w_stuck_low_next;
  logic             w_sat, w_capture, w_set_sh, w_set_sl, w_clear_stuck;

  assign w_sat = (r_cnt == c_sat);

  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      r_state      <= SEEK;
      r_cnt        <= '0;
      r_hi_cap     <= '0;
      r_period     <= '0;
      r_high       <= '0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
      r_stuck_high <= 1'b0;
      r_stuck_low  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_hi_cap     <= w_hi_cap_next;
      r_period     <= w_period_next;
      r_high       <= w_high_next;
      r_valid      <= w_valid_next;
      r_overrun    <= w_overrun_next;
      r_stuck_high <= w_stuck_high_next;
      r_stuck_low  <= w_stuck_low_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = (w_tick && !w_sat) ? (r_cnt + c_one) : r_cnt;
    w_hi_cap_next = r_hi_cap;
    w_capture     = 1'b0;
    w_set_sh      = 1'b0;
    w_set_sl      = 1'b0;
    w_clear_stuck = 1'b0;

    // A rise always restarts the count, so a coincident tick is dropped.
    case (r_state)
      SEEK: begin
        if (w_rise) begin
          w_cnt_next    = '0;
          w_clear_stuck = 1'b1;
          w_state_next  = HIGH;
        end else if (w_sat) begin
          w_set_sh = w_pwm_s;
          w_set_sl = ~w_pwm_s;
        end
      end
      HIGH: begin
        if (w_fall) begin
          w_hi_cap_next = r_cnt;
          w_state_next  = LOW;
        end else if (w_sat) begin
          w_set_sh     = 1'b1;
          w_state_next = SEEK;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_capture     = 1'b1;
          w_cnt_next    = '0;
          w_clear_stuck = 1'b1;
          w_state_next  = HIGH;
        end else if (w_sat) begin
          w_set_sl     = 1'b1;
          w_state_next = SEEK;
        end
      end
      default: begin
        w_state_next = SEEK;
      end
    endcase

    w_period_next     = w_capture ? r_cnt    : r_period;
    w_high_next       = w_capture ? r_hi_cap : r_high;
    w_valid_next      = w_capture ? 1'b1 : (ack ? 1'b0 : r_valid);
    w_overrun_next    = ack ? 1'b0 : (r_overrun | (w_capture & r_valid));

    // Setting one stuck flag drops the other so they stay exclusive.
    w_stuck_high_next = r_stuck_high;
    w_stuck_low_next  = r_stuck_low;
    if (w_clear_stuck) begin
      w_stuck_high_next = 1'b0;
      w_stuck_low_next  = 1'b0;
    end else if (w_set_sh) begin
      w_stuck_high_next = 1'b1;
      w_stuck_low_next  = 1'b0;
    end else if (w_set_sl) begin
      w_stuck_high_next = 1'b0;
      w_stuck_low_next  = 1'b1;
    end
  end

  assign period        = r_period;
  assign high_time     = r_high;
  assign capture_valid = r_valid;
  assign overrun       = r_overrun;
  assign stuck_high    = r_stuck_high;
  assign stuck_low     = r_stuck_low;

endmodule
`default_nettype wire
